// File: rtl/reg_alu_multicycle.sv
// Multi-cycle register-file/ALU/data-memory datapath: one instruction per start, IDLE->DECODE->EXEC->(MEM)->WB.
// Latency 4 edges (5 with memory access) from the accepting edge; start is ignored while busy, no queuing.
module reg_alu_multicycle #(
  parameter int WIDTH     = 32,
  parameter int REG_COUNT = 32,
  parameter int MEM_DEPTH = 64,
  localparam int AW = $clog2(REG_COUNT),
  localparam int MW = $clog2(MEM_DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [AW-1:0]    rs,
  input  logic [AW-1:0]    rt,
  input  logic [AW-1:0]    rd,
  input  logic [15:0]      immediate,
  input  logic [5:0]       FuncCode,
  input  logic [1:0]       ALUOp,
  input  logic             RegDst,
  input  logic             ALUSrc,
  input  logic             MemWrite,
  input  logic             MemRead,
  input  logic             MemToReg,
  input  logic             RegWrite,
  output logic             busy,
  output logic             done,
  output logic             Zero,
  output logic [WIDTH-1:0] ReadData
);

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;

  state_t state;

  // Instruction register: inputs are sampled once, on the accepting edge
  logic [AW-1:0] irRs;
  logic [AW-1:0] irRt;
  logic [AW-1:0] irRd;
  logic [15:0]   irImm;
  logic [5:0]    irFunc;
  logic [1:0]    irAluOp;
  logic          irRegDst;
  logic          irAluSrc;
  logic          irMemWrite;
  logic          irMemRead;
  logic          irMemToReg;
  logic          irRegWrite;

  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [AW-1:0]    target;
  logic [WIDTH-1:0] aluOut;
  logic [WIDTH-1:0] mdr;

  logic [WIDTH-1:0] regFile [REG_COUNT];
  logic [WIDTH-1:0] dataMem [MEM_DEPTH];

  logic [WIDTH-1:0] immExt;
  logic [WIDTH-1:0] aluOp2;
  logic [WIDTH-1:0] aluResult;
  logic [WIDTH-1:0] wbValue;
  logic [MW-1:0]    memAddr;

  if (WIDTH > 16) begin : gImmExt
    assign immExt = {{(WIDTH-16){irImm[15]}}, irImm};
  end else begin : gImmTrunc
    assign immExt = irImm[WIDTH-1:0];
  end

  assign aluOp2  = irAluSrc ? immExt : bReg;
  assign memAddr = aluOut[MW+1:2];
  assign wbValue = irMemToReg ? mdr : aluOut;

  always_comb begin
    aluResult = '0;
    case (irAluOp)
      2'b01: aluResult = aReg - aluOp2;
      2'b10: begin
        case (irFunc)
          6'h20:   aluResult = aReg + aluOp2;
          6'h22:   aluResult = aReg - aluOp2;
          6'h24:   aluResult = aReg & aluOp2;
          6'h25:   aluResult = aReg | aluOp2;
          6'h27:   aluResult = ~(aReg | aluOp2);
          6'h2A:   aluResult = {{(WIDTH-1){1'b0}}, ($signed(aReg) < $signed(aluOp2))};
          default: aluResult = '0;
        endcase
      end
      default: aluResult = aReg + aluOp2;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      Zero       <= 1'b0;
      ReadData   <= '0;
      irRs       <= '0;
      irRt       <= '0;
      irRd       <= '0;
      irImm      <= '0;
      irFunc     <= '0;
      irAluOp    <= '0;
      irRegDst   <= 1'b0;
      irAluSrc   <= 1'b0;
      irMemWrite <= 1'b0;
      irMemRead  <= 1'b0;
      irMemToReg <= 1'b0;
      irRegWrite <= 1'b0;
      aReg       <= '0;
      bReg       <= '0;
      target     <= '0;
      aluOut     <= '0;
      mdr        <= '0;
      for (int i = 0; i < REG_COUNT; i++) regFile[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            irRs       <= rs;
            irRt       <= rt;
            irRd       <= rd;
            irImm      <= immediate;
            irFunc     <= FuncCode;
            irAluOp    <= ALUOp;
            irRegDst   <= RegDst;
            irAluSrc   <= ALUSrc;
            irMemWrite <= MemWrite;
            irMemRead  <= MemRead;
            irMemToReg <= MemToReg;
            irRegWrite <= RegWrite;
            busy       <= 1'b1;
            state      <= DECODE;
          end
        end
        DECODE: begin
          // Register 0 is never written, so it reads back as zero
          aReg   <= regFile[irRs];
          bReg   <= regFile[irRt];
          target <= irRegDst ? irRd : irRt;
          state  <= EXEC;
        end
        EXEC: begin
          aluOut <= aluResult;
          Zero   <= (aluResult == '0);
          state  <= (irMemRead || irMemWrite) ? MEM : WB;
        end
        MEM: begin
          // Nonblocking read sees the pre-write contents when both are set
          if (irMemRead) mdr <= dataMem[memAddr];
          state <= WB;
        end
        WB: begin
          ReadData <= wbValue;
          if (irRegWrite && (target != '0)) regFile[target] <= wbValue;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data memory has no reset; contents survive an aborted instruction
  always_ff @(posedge clock) begin
    if ((state == MEM) && irMemWrite) dataMem[memAddr] <= bReg;
  end

endmodule

// File: tb/tb_reg_alu_multicycle.sv
// Randomized plus directed bench for reg_alu_multicycle against an instruction-level reference model.
module tb_reg_alu_multicycle;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [5:0]  fc;
    logic [1:0]  op;
    logic        regDst;
    logic        aluSrc;
    logic        memWrite;
    logic        memRead;
    logic        memToReg;
    logic        regWrite;
  } instr_t;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] immediate;
  logic [5:0]  FuncCode;
  logic [1:0]  ALUOp;
  logic        RegDst;
  logic        ALUSrc;
  logic        MemWrite;
  logic        MemRead;
  logic        MemToReg;
  logic        RegWrite;
  logic        busy;
  logic        done;
  logic        Zero;
  logic [31:0] ReadData;

  int checks = 0;
  int errors = 0;

  logic [31:0] mRegs [32];
  logic [31:0] mMem  [64];
  logic [31:0] mMdr;

  reg_alu_multicycle #(.WIDTH(32), .REG_COUNT(32), .MEM_DEPTH(64)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .rs(rs), .rt(rt), .rd(rd), .immediate(immediate), .FuncCode(FuncCode), .ALUOp(ALUOp),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .MemWrite(MemWrite), .MemRead(MemRead),
    .MemToReg(MemToReg), .RegWrite(RegWrite),
    .busy(busy), .done(done), .Zero(Zero), .ReadData(ReadData)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] refAlu(input logic [1:0] op, input logic [5:0] fc,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = a + b;
    if (op == 2'd1) r = a - b;
    else if (op == 2'd2) begin
      case (fc)
        6'h20:   r = a + b;
        6'h22:   r = a - b;
        6'h24:   r = a & b;
        6'h25:   r = a | b;
        6'h27:   r = ~(a | b);
        6'h2A:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: r = 32'd0;
      endcase
    end
    return r;
  endfunction

  function automatic instr_t mkR(input logic [5:0] fc, input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    instr_t i;
    i = '0;
    i.fc = fc; i.rd = d; i.rs = s; i.rt = t;
    i.op = 2'd2; i.regDst = 1'b1; i.regWrite = 1'b1;
    return i;
  endfunction

  function automatic instr_t mkI(input logic [1:0] op, input logic [4:0] t, input logic [4:0] s, input logic [15:0] imm);
    instr_t i;
    i = '0;
    i.op = op; i.rt = t; i.rs = s; i.imm = imm;
    i.aluSrc = 1'b1; i.regWrite = 1'b1;
    return i;
  endfunction

  function automatic instr_t mkSw(input logic [4:0] t, input logic [4:0] s, input logic [15:0] imm);
    instr_t i;
    i = mkI(2'd0, t, s, imm);
    i.regWrite = 1'b0; i.memWrite = 1'b1;
    return i;
  endfunction

  function automatic instr_t mkLw(input logic [4:0] t, input logic [4:0] s, input logic [15:0] imm);
    instr_t i;
    i = mkI(2'd0, t, s, imm);
    i.memRead = 1'b1; i.memToReg = 1'b1;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    rs = i.rs; rt = i.rt; rd = i.rd; immediate = i.imm; FuncCode = i.fc; ALUOp = i.op;
    RegDst = i.regDst; ALUSrc = i.aluSrc; MemWrite = i.memWrite; MemRead = i.memRead;
    MemToReg = i.memToReg; RegWrite = i.regWrite;
  endtask

  task automatic scramble();
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); immediate = 16'($urandom);
    FuncCode = 6'($urandom); ALUOp = 2'($urandom); RegDst = 1'($urandom); ALUSrc = 1'($urandom);
    MemWrite = 1'($urandom); MemRead = 1'($urandom); MemToReg = 1'($urandom); RegWrite = 1'($urandom);
  endtask

  task automatic modelReset();
    for (int k = 0; k < 32; k++) mRegs[k] = 32'd0;
    mMdr = 32'd0;
  endtask

  // Issues one instruction, advances the model, and checks handshake, latency and results.
  // Returns at #1 after the done edge, so a following call starts in the done cycle.
  task automatic runInstr(input instr_t i, input int pulseAt);
    logic [31:0] a, b, op2, res, wb;
    logic [5:0]  addr;
    logic [4:0]  tgt;
    int          expLat, n;
    a      = mRegs[i.rs];
    b      = mRegs[i.rt];
    op2    = i.aluSrc ? {{16{i.imm[15]}}, i.imm} : b;
    res    = refAlu(i.op, i.fc, a, op2);
    addr   = res[7:2];
    expLat = (i.memRead || i.memWrite) ? 5 : 4;
    if (i.memRead) mMdr = mMem[addr];
    if (i.memWrite) mMem[addr] = b;
    wb  = i.memToReg ? mMdr : res;
    tgt = i.regDst ? i.rd : i.rt;
    if (i.regWrite && tgt != 5'd0) mRegs[tgt] = wb;

    drive(i);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    scramble();
    check("busy_after_accept", 32'(busy), 32'd1);
    n = 1;
    while (done !== 1'b1 && n < 12) begin
      start = (n == pulseAt);
      @(posedge clock);
      #1;
      start = 1'b0;
      n++;
    end
    check("latency", 32'(n), 32'(expLat));
    check("done_pulse", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd0);
    check("ReadData", ReadData, wb);
    check("Zero", 32'(Zero), 32'(res == 32'd0));
  endtask

  task automatic readReg(input logic [4:0] r, input logic [31:0] exp);
    instr_t i;
    i = mkR(6'h20, 5'd0, r, 5'd0);
    i.regWrite = 1'b0;
    runInstr(i, 0);
    check("reg_readback", ReadData, exp);
  endtask

  initial begin
    instr_t ins;
    int     pick;
    logic [5:0] fcList [8];
    fcList[0] = 6'h20; fcList[1] = 6'h22; fcList[2] = 6'h24; fcList[3] = 6'h25;
    fcList[4] = 6'h27; fcList[5] = 6'h2A; fcList[6] = 6'h21; fcList[7] = 6'h3F;

    reset_n = 1'b0;
    start   = 1'b0;
    drive('0);
    modelReset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_Zero", 32'(Zero), 32'd0);
    check("rst_ReadData", ReadData, 32'd0);

    // Give every memory word a known value
    for (int k = 0; k < 64; k++) runInstr(mkSw(5'd0, 5'd0, 16'(k * 4)), 0);

    // Reset in the middle of EXEC for addi r5,r1,3
    runInstr(mkI(2'd0, 5'd1, 5'd0, 16'd7), 0);
    drive(mkI(2'd0, 5'd5, 5'd1, 16'd3));
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_Zero", 32'(Zero), 32'd0);
    check("abort_ReadData", ReadData, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    modelReset();
    readReg(5'd5, 32'd0);
    readReg(5'd1, 32'd0);

    // R-type chain
    runInstr(mkI(2'd0, 5'd1, 5'd0, 16'd7), 0);
    runInstr(mkI(2'd0, 5'd2, 5'd0, 16'd5), 0);
    runInstr(mkR(6'h22, 5'd3, 5'd1, 5'd2), 0);
    check("sub_value", ReadData, 32'd2);
    check("sub_zero", 32'(Zero), 32'd0);
    runInstr(mkR(6'h2A, 5'd4, 5'd2, 5'd1), 0);
    check("slt_value", ReadData, 32'd1);
    runInstr(mkR(6'h27, 5'd6, 5'd0, 5'd0), 0);
    check("nor_value", ReadData, 32'hFFFF_FFFF);

    // Memory, including address wrap
    runInstr(mkSw(5'd1, 5'd0, 16'd8), 0);
    runInstr(mkLw(5'd7, 5'd0, 16'd8), 0);
    check("lw_value", ReadData, 32'd7);
    runInstr(mkLw(5'd8, 5'd0, 16'(4 * 64 + 8)), 0);
    check("lw_wrap", ReadData, 32'd7);
    readReg(5'd7, 32'd7);

    // Register 0 discards writes
    runInstr(mkR(6'h20, 5'd0, 5'd1, 5'd1), 0);
    check("r0_add_value", ReadData, 32'd14);
    readReg(5'd0, 32'd0);

    // start pulsed while busy is ignored
    runInstr(mkR(6'h20, 5'd9, 5'd1, 5'd2), 2);
    for (int k = 0; k < 4; k++) begin
      @(posedge clock);
      #1;
      check("no_extra_done", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end

    // Back-to-back dependent pair, second start in the done cycle
    runInstr(mkI(2'd0, 5'd10, 5'd9, 16'd1), 0);
    runInstr(mkR(6'h20, 5'd11, 5'd10, 5'd10), 0);
    check("raw_value", ReadData, 32'd26);

    // Zero flag on a compare that writes nothing
    runInstr(mkI(2'd0, 5'd1, 5'd0, 16'd9), 0);
    runInstr(mkI(2'd0, 5'd2, 5'd0, 16'd9), 0);
    ins = mkR(6'h00, 5'd12, 5'd1, 5'd2);
    ins.op = 2'd1;
    ins.regWrite = 1'b0;
    runInstr(ins, 0);
    check("beq_zero", 32'(Zero), 32'd1);
    readReg(5'd12, 32'd0);
    readReg(5'd1, 32'd9);

    // Read and write in one instruction: old word returned, new word stored
    ins = mkLw(5'd1, 5'd0, 16'd8);
    ins.memWrite = 1'b1;
    runInstr(ins, 0);
    check("rmw_old", ReadData, 32'd7);
    runInstr(mkLw(5'd13, 5'd0, 16'd8), 0);
    check("rmw_new", ReadData, 32'd9);

    // Randomized instructions with occasional idle gaps
    for (int k = 0; k < 200; k++) begin
      ins.rs       = 5'($urandom);
      ins.rt       = 5'($urandom);
      ins.rd       = 5'($urandom);
      ins.imm      = 16'($urandom);
      ins.op       = 2'($urandom);
      ins.fc       = fcList[$urandom_range(0, 7)];
      ins.regDst   = 1'($urandom);
      ins.aluSrc   = 1'($urandom);
      ins.memToReg = 1'($urandom);
      ins.regWrite = ($urandom_range(0, 3) != 0);
      pick         = $urandom_range(0, 7);
      ins.memWrite = (pick == 1 || pick == 2 || pick == 7);
      ins.memRead  = (pick == 3 || pick == 4 || pick == 7);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clock);
      runInstr(ins, 0);
    end

    for (int r = 0; r < 32; r++) readReg(5'(r), mRegs[r]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
